// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper motor profiler.
// Holds the microstep code constants and the ustep FSM state encoding.
package stepper_pkg;

    localparam logic [1:0] USTEP_FULL    = 2'd0;
    localparam logic [1:0] USTEP_HALF    = 2'd1;
    localparam logic [1:0] USTEP_QUARTER = 2'd2;
    localparam logic [1:0] USTEP_FINE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_DWELL = 2'd2
    } ustep_state_t;

endpackage

// File: rtl/stepper_current_slew.sv
// Current command slew limiter.
// Clamps the raw current target to current_limit and walks peak_current
// toward it by at most CUR_STEP every RAMP_DIV enabled cycles.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   enable             slew enable; when low the divider clears and peak holds
//   target_raw [TW]    unclamped target (2*rpm + offset)
//   current_limit      ceiling; a limit below peak loads peak immediately
//   peak_current       registered current command
//   peak_next          value peak_current takes on the next edge
//   target             clamped target
module stepper_current_slew #(
    parameter int TW       = 20,
    parameter int CUR_W    = 8,
    parameter int RAMP_DIV = 4,
    parameter int CUR_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [TW-1:0]    target_raw,
    input  logic [CUR_W-1:0] current_limit,
    output logic [CUR_W-1:0] peak_current,
    output logic [CUR_W-1:0] peak_next,
    output logic [CUR_W-1:0] target
);

    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DW-1:0]    DIV_LAST = DW'(RAMP_DIV - 1);
    localparam logic [CUR_W-1:0] STEP     = CUR_W'(CUR_STEP);

    logic [DW-1:0]    div_q, div_d;
    logic [CUR_W-1:0] peak_q;
    logic [CUR_W-1:0] diff;

    assign target = (target_raw > TW'(current_limit)) ? current_limit
                                                      : target_raw[CUR_W-1:0];

    // The limit override is a safety ceiling, so it wins even while disabled.
    always_comb begin
        peak_next = peak_q;
        div_d     = div_q;
        diff      = '0;
        if (current_limit < peak_q) begin
            peak_next = current_limit;
            div_d     = '0;
        end else if (!enable) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            if (target > peak_q) begin
                diff      = target - peak_q;
                peak_next = peak_q + ((diff > STEP) ? STEP : diff);
            end else if (target < peak_q) begin
                diff      = peak_q - target;
                peak_next = peak_q - ((diff > STEP) ? STEP : diff);
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            peak_q <= '0;
        end else begin
            div_q  <= div_d;
            peak_q <= peak_next;
        end
    end

    assign peak_current = peak_q;

endmodule

// File: rtl/stepper_motor_profiler.sv
// Stepper motor profiler: selects the microstep resolution from the
// commanded RPM (with downshift hysteresis and a dwell filter) and slews
// the peak current command toward 2*rpm + DAC_OFFSET, clamped to a limit.
// Ports:
//   clk, reset_n    clock, async active-low reset
//   enable          tracking enable
//   rpm_int_vel     commanded RPM
//   current_limit   peak current ceiling
//   peak_current    slewed current command
//   usteps          microstep code (3 = finest, 0 = full step)
//   ustep_chg       one-cycle strobe on a usteps update
//   busy            dwell counting or peak_current not at target
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | tracking disabled; usteps held, dwell counter clear
// S_TRACK | candidate equals usteps; waiting for a change
// S_DWELL | candidate differs; counting consecutive cycles it persists
module stepper_motor_profiler
    import stepper_pkg::*;
#(
    parameter int RPM_W      = 18,
    parameter int CUR_W      = 8,
    parameter int LIM_USTEP2 = 40,
    parameter int LIM_USTEP1 = 100,
    parameter int LIM_USTEP0 = 160,
    parameter int HYST       = 4,
    parameter int DWELL      = 16,
    parameter int DAC_OFFSET = 12,
    parameter int RAMP_DIV   = 4,
    parameter int CUR_STEP   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [RPM_W-1:0] rpm_int_vel,
    input  logic [CUR_W-1:0] current_limit,
    output logic [CUR_W-1:0] peak_current,
    output logic [1:0]       usteps,
    output logic             ustep_chg,
    output logic             busy
);

    localparam int TW = RPM_W + 2;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    localparam logic [RPM_W-1:0] L2 = RPM_W'(LIM_USTEP2);
    localparam logic [RPM_W-1:0] L1 = RPM_W'(LIM_USTEP1);
    localparam logic [RPM_W-1:0] L0 = RPM_W'(LIM_USTEP0);
    // Downshift bounds, saturating at zero.
    localparam logic [RPM_W-1:0] L2_DN = RPM_W'((LIM_USTEP2 > HYST) ? LIM_USTEP2 - HYST : 0);
    localparam logic [RPM_W-1:0] L1_DN = RPM_W'((LIM_USTEP1 > HYST) ? LIM_USTEP1 - HYST : 0);
    localparam logic [RPM_W-1:0] L0_DN = RPM_W'((LIM_USTEP0 > HYST) ? LIM_USTEP0 - HYST : 0);

    ustep_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       cand_q, cand_d;
    logic [1:0]       usteps_q, usteps_d;
    logic             chg_q, chg_d;
    logic             busy_q;
    logic [1:0]       raw, cand;
    logic [RPM_W-1:0] bound;
    logic [TW-1:0]    target_raw;
    logic [CUR_W-1:0] peak_next, target;

    always_comb begin
        if (rpm_int_vel < L2)      raw = USTEP_FINE;
        else if (rpm_int_vel < L1) raw = USTEP_QUARTER;
        else if (rpm_int_vel < L0) raw = USTEP_HALF;
        else                       raw = USTEP_FULL;
    end

    // A move to a finer code must clear the lower edge of the current
    // region by HYST; a coarser move is taken straight from the raw region.
    always_comb begin
        cand = raw;
        case (usteps_q)
            USTEP_FULL: bound = L0_DN;
            USTEP_HALF: bound = L1_DN;
            default:    bound = L2_DN;
        endcase
        if ((raw > usteps_q) && !(rpm_int_vel < bound))
            cand = usteps_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        usteps_d = usteps_q;
        chg_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = S_TRACK;
            end
            S_TRACK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cand != usteps_q) begin
                    state_d = S_DWELL;
                    cnt_d   = '0;
                    cand_d  = cand;
                end
            end
            S_DWELL: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cand == usteps_q) begin
                    state_d = S_TRACK;
                    cnt_d   = '0;
                end else if (cand != cand_q) begin
                    cnt_d  = '0;
                    cand_d = cand;
                end else if (cnt_q == DWELL_LAST) begin
                    usteps_d = cand;
                    chg_d    = 1'b1;
                    state_d  = S_TRACK;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cand_q   <= USTEP_FINE;
            usteps_q <= USTEP_FINE;
            chg_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            usteps_q <= usteps_d;
            chg_q    <= chg_d;
            busy_q   <= (state_d == S_DWELL) || (peak_next != target);
        end
    end

    // Widened before doubling so the maximum RPM cannot wrap.
    assign target_raw = (TW'(rpm_int_vel) << 1) + TW'(DAC_OFFSET);

    stepper_current_slew #(
        .TW       (TW),
        .CUR_W    (CUR_W),
        .RAMP_DIV (RAMP_DIV),
        .CUR_STEP (CUR_STEP)
    ) u_slew (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .target_raw    (target_raw),
        .current_limit (current_limit),
        .peak_current  (peak_current),
        .peak_next     (peak_next),
        .target        (target)
    );

    assign usteps    = usteps_q;
    assign ustep_chg = chg_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_stepper_motor_profiler.sv
module tb_stepper_motor_profiler;

    localparam int DWELL = 16;
    localparam int RAMP  = 4;
    localparam int STEP  = 1;
    localparam int HYST  = 4;
    localparam int OFS   = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic [17:0] rpm = '0;
    logic [7:0]  lim = 8'd255;
    logic [7:0]  peak_current;
    logic [1:0]  usteps;
    logic        ustep_chg;
    logic        busy;

    int total = 0;
    int passed = 0;
    int chg_seen = 0;

    // reference model state
    int  m_us, m_peak, m_phase, m_run, m_prev;
    bit  m_tracking, m_chg, m_busy;

    always #5 clk = ~clk;

    stepper_motor_profiler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .rpm_int_vel   (rpm),
        .current_limit (lim),
        .peak_current  (peak_current),
        .usteps        (usteps),
        .ustep_chg     (ustep_chg),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int region(int r);
        if (r < 40)  return 3;
        if (r < 100) return 2;
        if (r < 160) return 1;
        return 0;
    endfunction

    // lower edge of region u, less hysteresis, floored at zero
    function automatic int down_bound(int u);
        int thr;
        thr = (u == 0) ? 160 : (u == 1) ? 100 : 40;
        return (thr > HYST) ? thr - HYST : 0;
    endfunction

    function automatic int candidate(int r, int us);
        int g;
        g = region(r);
        if (g > us && !(r < down_bound(us))) return us;
        return g;
    endfunction

    function automatic int target_of(int r, int l);
        int t;
        t = 2 * r + OFS;
        return (t > l) ? l : t;
    endfunction

    task automatic model_reset();
        m_us = 3; m_peak = 0; m_phase = 0; m_run = 0; m_prev = 3;
        m_tracking = 0; m_chg = 0; m_busy = 0;
    endtask

    // m_run = number of consecutive tracked edges the same new candidate was seen
    task automatic model_edge();
        int c, t, d, r, l;
        r = int'(rpm);
        l = int'(lim);
        c = candidate(r, m_us);
        t = target_of(r, l);
        m_chg = 0;
        if (!enable) begin
            m_tracking = 0; m_run = 0;
        end else if (!m_tracking) begin
            m_tracking = 1; m_run = 0;
        end else if (c == m_us) begin
            m_run = 0;
        end else if (m_run == 0 || c != m_prev) begin
            m_run = 1; m_prev = c;
        end else if (m_run == DWELL) begin
            m_us = c; m_chg = 1; m_run = 0;
        end else begin
            m_run++;
        end
        if (l < m_peak) begin
            m_peak = l; m_phase = 0;
        end else if (!enable) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == RAMP) begin
                m_phase = 0;
                d = (t > m_peak) ? t - m_peak : m_peak - t;
                if (d > STEP) d = STEP;
                if (t > m_peak) m_peak += d;
                else            m_peak -= d;
            end
        end
        m_busy = (m_run > 0) || (m_peak != t);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (ustep_chg === 1'b1) chg_seen++;
        chk("usteps", usteps, m_us);
        chk("peak_current", peak_current, m_peak);
        chk("ustep_chg", ustep_chg, m_chg);
        chk("busy", busy, m_busy);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_usteps", usteps, 3);
        chk("arst_peak", peak_current, 0);
        chk("arst_chg", ustep_chg, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_hold_usteps", usteps, 3);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_usteps", usteps, 3);
        chk("rst_peak", peak_current, 0);
        chk("rst_chg", ustep_chg, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;

        // 0 -> 120 rpm: usteps 3 -> 1 exactly DWELL edges after the first sampling edge
        enable = 1'b1;
        tick();
        rpm = 18'd120;
        chg_seen = 0;
        repeat (DWELL) tick();
        chk("s31_before", usteps, 3);
        tick();
        chk("s31_after", usteps, 1);
        chk("s31_strobe", ustep_chg, 1);
        repeat (10) tick();
        chk("s31_pulses", chg_seen, 1);

        // hysteresis on the 100 boundary
        rpm = 18'd100; repeat (30) tick();
        chk("s32_100", usteps, 1);
        rpm = 18'd97;  repeat (30) tick();
        chk("s32_97", usteps, 1);
        rpm = 18'd95;  repeat (DWELL) tick();
        chk("s32_95_before", usteps, 1);
        tick();
        chk("s32_95_after", usteps, 2);

        // ramp from zero at rpm 50 up to 112, then a limit drop
        rpm = 18'd50; lim = 8'd255;
        async_reset();
        repeat (460) tick();
        chk("s34_peak", peak_current, 112);
        chk("s34_idle", busy, 0);
        lim = 8'd60;
        tick();
        chk("s34_limit", peak_current, 60);

        // 39/41 chatter never survives the dwell
        lim = 8'd255; rpm = 18'd39;
        async_reset();
        tick();
        for (int i = 0; i < 20; i++) begin
            rpm = (i % 2 == 0) ? 18'd41 : 18'd39;
            for (int k = 0; k < 5; k++) begin
                tick();
                chk("s33_usteps", usteps, 3);
                chk("s33_busy", busy, 1);
            end
        end

        // maximum rpm: target clamps to the limit without wrapping
        rpm = 18'h3FFFF; lim = 8'd200;
        repeat (760) tick();
        chk("s35_peak", peak_current, 200);
        chk("s35_usteps", usteps, 0);

        // reset mid-dwell and mid-ramp, then resume from IDLE
        rpm = 18'd10;
        repeat (6) tick();
        async_reset();
        repeat (DWELL + 6) tick();

        // randomized tail
        for (int i = 0; i < 120; i++) begin
            int sel;
            enable = ($urandom_range(0, 7) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                int base;
                base = (sel < 2) ? 40 : (sel < 4) ? 100 : 160;
                rpm = 18'(base - 8 + $urandom_range(0, 16));
            end else if (sel < 9) begin
                rpm = 18'($urandom_range(0, 300));
            end else begin
                rpm = 18'h3FFFF;
            end
            lim = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd255;
            if (i == 60) async_reset();
            repeat ($urandom_range(1, 24)) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
